// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Width of one processed slice of the operands.
    localparam int NIBBLE_W = 4;

    // Control states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle between the operand source and the serial adder.
// Handshake: start is sampled on every rising clk edge and is accepted only
// while busy is low; x/y are captured on that same edge and ignored otherwise.
// done is a one-cycle strobe marking z/carry as final; z/carry then hold until
// the next accepted start. dbg_state mirrors the internal FSM state.
interface nibble_serial_adder_if
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             carry;
    state_t           dbg_state;

    modport master (
        output start, x, y,
        input  busy, done, z, carry, dbg_state
    );

    modport slave (
        input  start, x, y,
        output busy, done, z, carry, dbg_state
    );
endinterface

// File: rtl/nibble_serial_adder_nibble_adder_ci.sv
// 4-bit ripple-carry adder with carry in, built from single-bit full adders.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_adder_ci
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);
    // w_c[k] is the carry into bit k; w_c[NIBBLE_W] leaves the nibble.
    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[NIBBLE_W];

    for (genvar g = 0; g < NIBBLE_W; g++) begin : g_bit
        full_adder u_fa (
            .a    (a[g]),
            .b    (b[g]),
            .cin  (w_c[g]),
            .s    (s[g]),
            .cout (w_c[g+1])
        );
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LSB first, with the
// nibble carry registered between cycles. A single nibble adder is shared.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    nibble_serial_adder_if.slave   bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH-1:0]      r_xa;
    logic [WIDTH-1:0]      r_ya;
    logic [WIDTH-1:0]      r_z;
    logic                  r_cin;
    logic                  r_carry;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_accept;
    logic                  w_last;
    logic [NIBBLE_W-1:0]   w_a;
    logic [NIBBLE_W-1:0]   w_b;
    logic [NIBBLE_W-1:0]   w_s;
    logic                  w_cout;

    // Nibble selection from the latched operands.
    assign w_last = (r_idx == LAST_IDX);
    assign w_a    = r_xa[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b    = r_ya[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_adder_ci u_nibble (
        .a    (w_a),
        .b    (w_b),
        .cin  (r_cin),
        .s    (w_s),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and start acceptance; start is ignored while in RUN.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then fold one nibble per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xa    <= '0;
            r_ya    <= '0;
            r_z     <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_xa    <= bus.x;
            r_ya    <= bus.y;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_z[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
            r_cin <= w_cout;
            if (w_last) begin
                r_carry <= w_cout;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.z         = r_z;
    assign bus.carry     = r_carry;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and global time bound.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;
    logic [W:0] exp_q[$];

    // Driver: present an operand pair with start high and record its sum.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        exp_q.push_back({1'b0, a} + {1'b0, b});
    endtask

    // Wait (bounded) for the done strobe, counting busy cycles on the way.
    task automatic wait_done(input int max_cyc, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = i;
                return;
            end
        end
    endtask

    // Full operation from the negedge before the accepting edge up to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_total,
                          output logic carry_n1, output logic [W:0] got);
        int bn;
        drive_start(a, b);
        @(negedge clk);
        bus.start  = 1'b0;
        busy_total = bus.busy ? 1 : 0;
        carry_n1   = bus.carry;
        wait_done(20, lat, bn);
        busy_total += bn;
        got = {bus.carry, bus.z};
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.z !== '0 || bus.carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b z=%h carry=%b, required all 0",
                     bus.busy, bus.done, bus.z, bus.carry);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dbg_state !== IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: state=%0d busy=%b done=%b, required IDLE,0,0",
                     bus.dbg_state, bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int lat, bt;
        logic c1;
        logic [W:0] got, exp;
        run_op(16'h1234, 16'h4321, lat, bt, c1, got);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL basic_latency: done after %0d cycles, required 5", lat + 1);
        end
        checks++;
        if (bt !== 4) begin
            failures++;
            $display("FAIL basic_busy: busy for %0d cycles, required 4", bt);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== 17'h05555) begin
            failures++;
            $display("FAIL basic_sum: got %h, required %h", got, exp);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.z !== 16'h5555 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL basic_hold: done=%b z=%h state=%0d, required 0,5555,IDLE",
                     bus.done, bus.z, bus.dbg_state);
        end
    endtask

    // Carry boundary cases; also checks carry clears when the next start is taken.
    task automatic test_carry_cases();
        logic [W-1:0] va[3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
        logic [W-1:0] vb[3] = '{16'h0001, 16'h8000, 16'h0001};
        logic [W:0]   vr[3] = '{17'h10000, 17'h10000, 17'h08000};
        int lat, bt;
        logic c1;
        logic [W:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, bt, c1, got);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp || got !== vr[i] || lat !== 4) begin
                failures++;
                $display("FAIL carry_case%0d: got %h lat=%0d, required %h lat=4", i, got, lat, vr[i]);
            end
            if (i > 0) begin
                checks++;
                if (c1 !== 1'b0) begin
                    failures++;
                    $display("FAIL carry_clear%0d: carry=%b after accept, required 0", i, c1);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int pulses = 0;
        logic [W:0] got = 'x, exp;
        @(negedge clk);
        drive_start(16'h1234, 16'h4321);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x = 16'hAAAA;
        bus.y = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin
                pulses++;
                got = {bus.carry, bus.z};
            end
            @(negedge clk);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL busy_start_pulses: %0d done pulses, required 1", pulses);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL busy_start_sum: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bt, bn;
        logic c1;
        logic [W:0] got, exp;
        run_op(16'h1234, 16'h4321, lat, bt, c1, got);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_first: got %h, required %h", got, exp);
        end
        drive_start(16'h0F0F, 16'hF0F0);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.dbg_state !== RUN || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_rerun: state=%0d busy=%b, required RUN,1", bus.dbg_state, bus.busy);
        end
        wait_done(20, lat, bn);
        got = {bus.carry, bus.z};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || lat !== 4) begin
            failures++;
            $display("FAIL b2b_second: got %h lat=%0d, required %h lat=4", got, lat, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bt, pulses = 0;
        logic c1;
        logic [W:0] got, exp;
        @(negedge clk);
        drive_start(16'h1234, 16'h4321);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.z !== '0 || bus.carry !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b z=%h carry=%b, required all 0",
                     bus.busy, bus.done, bus.z, bus.carry);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL midrun_nodone: %0d pulses state=%0d, required 0,IDLE", pulses, bus.dbg_state);
        end
        run_op(16'hFFFF, 16'hFFFF, lat, bt, c1, got);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== 17'h1FFFE) begin
            failures++;
            $display("FAIL midrun_fresh: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_random();
        int lat, bt;
        logic c1;
        logic [W:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)), lat, bt, c1, got);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp || lat !== 4 || bt !== 4) begin
                failures++;
                $display("FAIL random%0d: got %h lat=%0d busy=%0d, required %h lat=4 busy=4",
                         i, got, lat, bt, exp);
            end
            if (($urandom_range(0, 1)) == 1) @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_carry_cases();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that slices two latched operands into 4-bit nibbles and adds one nibble per clock, LSB first.
- The carry out of each nibble is registered and fed into the next nibble as its carry in.
- Produces the full WIDTH-bit sum plus a final carry, and pulses a one-cycle done strobe.
- Sits directly downstream of the operand source and wraps a 4-bit adder stage with carry-in, extending the team's 4-bit adder datapath to wide words at one nibble slice of area.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived nibble count; localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on the rising clk edge.
- x  input  WIDTH  operand A; sampled only on the edge where start is accepted.
- y  input  WIDTH  operand B; sampled only on the edge where start is accepted.
- busy  output  1  high while an addition is in progress (state RUN).
- done  output  1  one-cycle strobe: z and carry are final.
- z  output  WIDTH  sum register.
- carry  output  1  final carry out of the MSB nibble.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, z=0, carry=0, nibble index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE. The state encoding is internal and free.
- IDLE:
  - start=1 latches x and y, clears the carry register, sets index=0, and moves to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - nibble sum = xa[4i+3:4i] + ya[4i+3:4i] + cin.
  - Write the nibble sum into z[4i+3:4i]; cin <= nibble cout; index++.
  - On the edge that processes nibble NIBBLES-1: carry <= cout and move to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: if start=1, accept new operands and go to RUN (back-to-back); otherwise go to IDLE.
- Latency:
  - start accepted at edge 0.
  - Nibbles are processed on edges 1..NIBBLES.
  - done is high in the cycle following edge NIBBLES.
  - Result is therefore available NIBBLES+1 cycles after start is sampled (5 cycles for WIDTH=16).
- busy=1 exactly in RUN. start is ignored while busy; the latched operands are not disturbed.
- z and carry hold their values from DONE until the next accepted start.
  - On acceptance, carry clears to 0 immediately.
  - z is overwritten nibble-by-nibble; upper nibbles keep stale data until they are written.
- Arithmetic is unsigned and modulo 2^WIDTH; overflow is reported only via carry.
- Changes on x/y after acceptance have no effect.
- Reset asserted mid-RUN aborts immediately to the reset values, with no done pulse. Deassertion returns to IDLE.
- WIDTH=4 degenerate case: a single RUN cycle, with done two cycles after start.

Decomposition:
- Shared package holds:
  - the FSM state constants (IDLE, RUN, DONE);
  - NIBBLE_W=4.
- One natural sub-module: nibble_adder_ci.
  - 4-bit ripple adder with carry in, built from the existing full_adder cell.
  - Ports: a[3:0], b[3:0], cin, s[3:0], cout.
  - Instantiated once; the nibble mux/demux lives in nibble_serial_adder.

Test Plan (WIDTH=16):
- Basic add: start with x=16'h1234, y=16'h4321 -> busy high for 4 cycles, done 5 cycles after start, z=16'h5555, carry=0.
- Full carry ripple: x=16'hFFFF, y=16'h0001 -> z=16'h0000, carry=1; every nibble carry propagates across cycles.
- MSB overflow only: x=16'h8000, y=16'h8000 -> z=16'h0000, carry=1. Then x=16'h7FFF, y=16'h0001 -> z=16'h8000, carry=0.
- Start during busy: pulse start with x=16'hAAAA, y=16'h1111 two cycles into a 16'h1234+16'h4321 operation -> result is still 16'h5555, with exactly one done pulse.
- Back-to-back: hold start=1 in the DONE cycle with x=16'h0F0F, y=16'hF0F0 -> returns to RUN without IDLE; second done yields z=16'hFFFF, carry=0.
- Reset mid-operation: assert reset asynchronously (between edges) during the second RUN cycle -> busy, done, z and carry go to 0 immediately, with no done pulse. A fresh start after release gives the correct sum.
